// File: rtl/dbus_interconnect.sv
// CPU data-bus interconnect: decodes reads/writes onto ascending base regions, stretches reads
// with a per-target ready handshake, aborts reads on timeout and reports unmapped accesses.
module dbus_interconnect #(
  parameter int                        NTARGETS    = 4,
  parameter int                        ADDRW       = 16,
  parameter int                        DATAW       = 16,
  parameter logic [NTARGETS*ADDRW-1:0] REGION_BASE = {16'h8000, 16'h4000, 16'h2000, 16'h0000},
  parameter int                        TIMEOUT     = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            dread_req,
  input  logic [ADDRW-1:0]                dread_addr,
  output logic [DATAW-1:0]                dread_data,
  output logic                            dread_valid,
  input  logic [ADDRW-1:0]                dwrite_addr,
  input  logic [DATAW-1:0]                dwrite_data,
  input  logic [DATAW/8-1:0]              dwrite_en,
  output logic                            stall,
  output logic [NTARGETS-1:0]             t_dread_req,
  output logic [NTARGETS*(DATAW/8)-1:0]   t_dwrite_en,
  input  logic [NTARGETS*DATAW-1:0]       t_dread_data,
  input  logic [NTARGETS-1:0]             t_ready,
  input  logic                            bus_error_clr,
  output logic                            bus_error,
  output logic [ADDRW-1:0]                err_addr
);

  localparam int NBYTES = DATAW / 8;
  localparam int SELW   = (NTARGETS > 1) ? $clog2(NTARGETS) : 1;

  typedef enum logic {S_IDLE, S_RWAIT} state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   rsel_q, rsel_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDRW-1:0]  raddr_q, raddr_d;
  logic              uerr_q, uerr_d;
  logic              bus_error_q, bus_error_d;
  logic [ADDRW-1:0]  err_addr_q, err_addr_d;

  logic [SELW-1:0]   rd_sel, wr_sel;
  logic              rd_hit, wr_hit;
  logic              rwait, sel_ready, timeout, rd_done, accept;
  logic              rd_err, wr_err;
  logic [ADDRW-1:0]  rd_err_addr;

  // Write data goes straight from the CPU to every target at SoC level.
  logic unused_wdata;
  assign unused_wdata = ^dwrite_data;

  // Bases ascend, so the last matching region is the owner.
  always_comb begin
    rd_sel = '0;
    rd_hit = 1'b0;
    wr_sel = '0;
    wr_hit = 1'b0;
    for (int i = 0; i < NTARGETS; i++) begin
      if (dread_addr >= REGION_BASE[i*ADDRW +: ADDRW]) begin
        rd_hit = 1'b1;
        rd_sel = SELW'(i);
      end
      if (dwrite_addr >= REGION_BASE[i*ADDRW +: ADDRW]) begin
        wr_hit = 1'b1;
        wr_sel = SELW'(i);
      end
    end
  end

  always_comb begin
    rwait     = (state_q == S_RWAIT);
    sel_ready = t_ready[rsel_q];
    timeout   = rwait && !sel_ready && (cnt_q == 8'(TIMEOUT));
    rd_done   = rwait && (sel_ready || timeout);
    stall     = rwait && !sel_ready && !timeout;
    accept    = dread_req && !stall;

    dread_valid = uerr_q || rd_done;
    if (rwait && sel_ready) begin
      dread_data = t_dread_data[rsel_q*DATAW +: DATAW];
    end else if (dread_valid) begin
      dread_data = '1;
    end else begin
      dread_data = '0;
    end

    t_dread_req = '0;
    if (rwait) begin
      t_dread_req[rsel_q] = 1'b1;
    end
    if (accept && rd_hit) begin
      t_dread_req         = '0;
      t_dread_req[rd_sel] = 1'b1;
    end

    t_dwrite_en = '0;
    if (!stall && wr_hit) begin
      t_dwrite_en[wr_sel*NBYTES +: NBYTES] = dwrite_en;
    end
  end

  always_comb begin
    state_d = state_q;
    rsel_d  = rsel_q;
    cnt_d   = cnt_q;
    raddr_d = raddr_q;
    uerr_d  = 1'b0;

    if (rwait && !rd_done) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (rd_done) begin
      state_d = S_IDLE;
    end
    if (accept) begin
      if (rd_hit) begin
        state_d = S_RWAIT;
        rsel_d  = rd_sel;
        cnt_d   = '0;
        raddr_d = dread_addr;
      end else begin
        uerr_d = 1'b1;
      end
    end

    // A timed-out read is older than a read issued in the same cycle, so it reports first.
    wr_err      = (|dwrite_en) && !stall && !wr_hit;
    rd_err      = timeout || (accept && !rd_hit);
    rd_err_addr = timeout ? raddr_q : dread_addr;

    bus_error_d = bus_error_q;
    err_addr_d  = err_addr_q;
    if (rd_err || wr_err) begin
      bus_error_d = 1'b1;
      if (!bus_error_q) begin
        err_addr_d = rd_err ? rd_err_addr : dwrite_addr;
      end
    end else if (bus_error_clr) begin
      bus_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rsel_q      <= '0;
      cnt_q       <= '0;
      raddr_q     <= '0;
      uerr_q      <= 1'b0;
      bus_error_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      rsel_q      <= rsel_d;
      cnt_q       <= cnt_d;
      raddr_q     <= raddr_d;
      uerr_q      <= uerr_d;
      bus_error_q <= bus_error_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign bus_error = bus_error_q;
  assign err_addr  = err_addr_q;

endmodule
